rgb2bram: RTL

- Capture side of the video frame buffer: the write-side counterpart of the BRAM-to-VGA scan-out block.
- Accepts a 640x480 RGB pixel stream with vsync, hsync and data-enable.
- Decimates 2:1 in both axes and writes the top 320x180 window into the 57600-word dual-port BRAM that the scan-out block reads.
- Sits between the receive-side pixel source and the BRAM write port, in the same pixel-clock domain.

---
 rtl/rgb2bram.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rgb2bram.sv
// rgb2bram: capture side of the video frame buffer.
// Takes a 640x480 RGB stream (vd/hd/den) in the pixel-clock domain, keeps
// every other pixel of every other line and writes the top 320x180 window
// into the dual-port BRAM that the scan-out block reads.
// Build option: define CAPTURE_HAVG_EN to store the per-channel average of
// each horizontal pixel pair instead of the even pixel alone.

module rgb2bram #(
  parameter int IN_W   = 640,
  parameter int OUT_W  = 320,
  parameter int OUT_H  = 180,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vd,
  input  logic              hd,
  input  logic              den,
  input  logic [23:0]       rgb_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [23:0]       ram_wdata,
  output logic              ram_we,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int COL_W  = $clog2(IN_W + 1);
  localparam int ROW_W  = $clog2(2 * OUT_H + 1) + 1;
  localparam int OROW_W = $clog2(OUT_H + 1);

  localparam logic [COL_W-1:0]  IN_W_C  = COL_W'(IN_W);
  localparam logic [OROW_W-1:0] OUT_H_C = OROW_W'(OUT_H);
  localparam logic [ADDR_W-1:0] OUT_W_A = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(OUT_W * OUT_H - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t              state;
  logic                vd_q;
  logic                den_q;
  logic [COL_W-1:0]    in_col;
  logic [ROW_W-1:0]    in_row;
  logic [OROW_W-1:0]   out_row;
  logic [ADDR_W-1:0]   line_base;
  logic                we_r;
  logic                done_r;
  logic                abort_r;

`ifdef CAPTURE_HAVG_EN
  logic                hold_valid;
  logic [ADDR_W-1:0]   hold_addr;
  logic [23:0]         hold_pix;

  function automatic logic [23:0] avg_pair(input logic [23:0] a, input logic [23:0] b);
    logic [8:0] sum;
    avg_pair = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = {1'b0, a[ch*8 +: 8]} + {1'b0, b[ch*8 +: 8]};
      avg_pair[ch*8 +: 8] = sum[8:1];
    end
  endfunction
`endif

  // hd is reserved; it is intentionally not used for line counting.
  logic unused_hd;
  assign unused_hd = hd;

  logic              vd_rise;
  logic              line_end;
  logic              keep;
  logic [ADDR_W-1:0] pix_addr;

  assign vd_rise  = vd & ~vd_q;
  assign line_end = den_q & ~den;
  assign keep     = den && (in_col < IN_W_C) && !in_col[0] && !in_row[0] && (out_row < OUT_H_C);
  assign pix_addr = line_base + ADDR_W'(in_col[COL_W-1:1]);

  // Strobes are held in registers while en is low and only shown on enabled cycles.
  assign ram_we      = we_r & en;
  assign frame_done  = done_r & en;
  assign frame_abort = abort_r & en;

  // Frame state machine, counters and the registered BRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vd_q      <= 1'b0;
      den_q     <= 1'b0;
      in_col    <= '0;
      in_row    <= '0;
      out_row   <= '0;
      line_base <= '0;
      we_r      <= 1'b0;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef CAPTURE_HAVG_EN
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_pix   <= '0;
`endif
    end else if (en) begin
      vd_q    <= vd;
      den_q   <= den;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      case (state)
        IDLE: begin
          if (vd_rise) state <= ACTIVE;
        end
        ACTIVE: begin
          if (we_r && ram_addr == LAST_A) begin
            // Final word is on the bus now; a coincident vd starts the next frame cleanly.
            done_r <= 1'b1;
            if (!vd_rise) state <= DONE;
          end else if (vd_rise) begin
            abort_r <= 1'b1;
          end else begin
            if (den) begin
              if (in_col != IN_W_C) in_col <= in_col + 1'b1;
`ifdef CAPTURE_HAVG_EN
              if (hold_valid) begin
                we_r       <= 1'b1;
                ram_addr   <= hold_addr;
                ram_wdata  <= avg_pair(hold_pix, rgb_in);
                hold_valid <= 1'b0;
              end else if (keep) begin
                hold_valid <= 1'b1;
                hold_addr  <= pix_addr;
                hold_pix   <= rgb_in;
              end
`else
              if (keep) begin
                we_r      <= 1'b1;
                ram_addr  <= pix_addr;
                ram_wdata <= rgb_in;
              end
`endif
            end
            if (line_end) begin
              in_col <= '0;
              if (in_row != '1) in_row <= in_row + 1'b1;
              if (!in_row[0] && out_row != OUT_H_C) begin
                out_row   <= out_row + 1'b1;
                line_base <= line_base + OUT_W_A;
              end
`ifdef CAPTURE_HAVG_EN
              if (hold_valid) begin
                we_r       <= 1'b1;
                ram_addr   <= hold_addr;
                ram_wdata  <= hold_pix;
                hold_valid <= 1'b0;
              end
`endif
            end
          end
        end
        DONE: begin
          if (vd_rise) state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
      if (vd_rise) begin
        in_col    <= '0;
        in_row    <= '0;
        out_row   <= '0;
        line_base <= '0;
`ifdef CAPTURE_HAVG_EN
        hold_valid <= 1'b0;
`endif
      end
    end
  end

endmodule
